wb_forward_stage: RTL and testbench

- Execute-to-writeback pipeline register for the tinytapeout RISC-V core.
- Holds the retiring destination register, data and write-enable, and drives the write address compared by the operand-forwarding comparator.
- Consumes the comparator's op1/op2 select lines to steer the ALU operands between register-file data and the in-flight result.
- Tracks outstanding loads and requests a pipeline stall until load data returns.

---
 rtl/wb_forward_stage.sv | 119 +++++++++++
 tb/tb_wb_forward_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wb_forward_stage.sv
// ---------------------------------------------------------------------------
// wb_forward_stage
// Execute-to-writeback pipeline register with operand forwarding and
// load-pending stall generation.
//
// Ports:
//   clk, rst           core clock (rising edge), async active-high reset
//   stall, flush       hazard-unit hold request / entry discard
//   ex_valid, ex_rd, ex_we, ex_is_load, ex_result
//                      instruction presented by the execute stage
//   mem_rvalid, mem_rdata
//                      returning load data
//   rs1_data, rs2_data register-file read ports
//   op1_select, op2_select
//                      forwarding comparator hits (rsN index == wb_rd)
//   wb_rd, wb_data     registered destination and write data
//   reg_we             register-file write enable
//   op1, op2           forwarded ALU operands
//   stall_req          stall request while a load is outstanding
// ---------------------------------------------------------------------------
module wb_forward_stage #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  ex_valid,
   input  logic [ADDR_WIDTH-1:0] ex_rd,
   input  logic                  ex_we,
   input  logic                  ex_is_load,
   input  logic [DATA_WIDTH-1:0] ex_result,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   input  logic                  op1_select,
   input  logic                  op2_select,
   output logic [ADDR_WIDTH-1:0] wb_rd,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  reg_we,
   output logic [DATA_WIDTH-1:0] op1,
   output logic [DATA_WIDTH-1:0] op2,
   output logic                  stall_req
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] VALID     = 2'd1;
   localparam logic [1:0] LOAD_PEND = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  we_q, we_d;

   logic hit1, hit2;

   // Priority: flush > load completion > accept > hold.
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      data_d  = data_q;
      we_d    = we_q;
      if (flush) begin
         state_d = IDLE;
         rd_d    = '0;
         we_d    = 1'b0;
      end else if (state_q == LOAD_PEND) begin
         // Load capture ignores the external stall; nothing new is accepted here.
         if (mem_rvalid) begin
            data_d  = mem_rdata;
            state_d = VALID;
         end
      end else if (!stall) begin
         if (!ex_valid) begin
            state_d = IDLE;
            we_d    = 1'b0;
         end else if (ex_is_load && ex_we) begin
            state_d = LOAD_PEND;
            rd_d    = ex_rd;
            data_d  = '0;
            we_d    = 1'b1;
         end else begin
            state_d = VALID;
            rd_d    = ex_rd;
            data_d  = ex_result;
            we_d    = ex_we;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rd_q    <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         we_q    <= we_d;
      end
   end

   always_comb begin
      wb_rd     = rd_q;
      wb_data   = data_q;
      stall_req = (state_q == LOAD_PEND);
      // x0 is hardwired to zero, so it is never written or forwarded.
      reg_we    = (state_q == VALID) && we_q && (rd_q != '0);
      hit1      = op1_select && reg_we;
      hit2      = op2_select && reg_we;
      op1       = hit1 ? data_q : rs1_data;
      op2       = hit2 ? data_q : rs2_data;
   end

endmodule

// File: tb/tb_wb_forward_stage.sv
module tb_wb_forward_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       stall, flush;
   logic       ex_valid, ex_we, ex_is_load;
   logic [4:0] ex_rd;
   logic [7:0] ex_result;
   logic       mem_rvalid;
   logic [7:0] mem_rdata, rs1_data, rs2_data;
   logic       op1_select, op2_select;
   logic [4:0] wb_rd;
   logic [7:0] wb_data, op1, op2;
   logic       reg_we, stall_req;

   int errors = 0;
   int checks = 0;

   wb_forward_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .ex_valid   (ex_valid),
      .ex_rd      (ex_rd),
      .ex_we      (ex_we),
      .ex_is_load (ex_is_load),
      .ex_result  (ex_result),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .op1_select (op1_select),
      .op2_select (op2_select),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .reg_we     (reg_we),
      .op1        (op1),
      .op2        (op2),
      .stall_req  (stall_req)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then driven and sampled mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 0; flush = 0;
      ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
      mem_rvalid = 0; mem_rdata = 0;
      rs1_data = 8'h21; rs2_data = 8'h22; op1_select = 0; op2_select = 0;
      step(); step();
      check("rst_reg_we", reg_we, 0);
      check("rst_stall_req", stall_req, 0);
      check("rst_op1", op1, 8'h21);

      // Establish wb_rd = 7, then reset asynchronously mid-cycle.
      rst = 0;
      ex_valid = 1; ex_rd = 7; ex_we = 1; ex_result = 8'h42;
      step();
      check("pre_rst_wb_rd", wb_rd, 7);
      check("pre_rst_reg_we", reg_we, 1);
      op1_select = 1;
      #2 rst = 1;
      #1;
      check("async_rst_wb_rd", wb_rd, 0);
      check("async_rst_reg_we", reg_we, 0);
      check("async_rst_stall_req", stall_req, 0);
      check("async_rst_op1", op1, 8'h21);
      step();
      rst = 0; op1_select = 0;

      // ALU forward.
      ex_valid = 1; ex_rd = 3; ex_we = 1; ex_result = 8'h5A;
      step();
      ex_valid = 0;
      op1_select = 1; rs1_data = 8'h11;
      #1;
      check("alu_op1_fwd", op1, 8'h5A);
      check("alu_reg_we", reg_we, 1);
      check("alu_wb_rd", wb_rd, 3);
      check("alu_wb_data", wb_data, 8'h5A);
      op1_select = 0;
      #1;
      check("alu_op1_nofwd", op1, 8'h11);

      // x0 guard.
      ex_valid = 1; ex_rd = 0; ex_we = 1; ex_result = 8'hFF;
      step();
      ex_valid = 0;
      op2_select = 1;
      #1;
      check("x0_op2", op2, 8'h22);
      check("x0_reg_we", reg_we, 0);

      // Load with two stall cycles.
      ex_valid = 1; ex_rd = 5; ex_we = 1; ex_is_load = 1;
      step();
      ex_valid = 0; ex_is_load = 0;
      check("ld_stall_c1", stall_req, 1);
      check("ld_wb_data_zero", wb_data, 0);
      check("ld_reg_we_pend", reg_we, 0);
      check("ld_op2_pend", op2, 8'h22);
      step();
      mem_rvalid = 1; mem_rdata = 8'h3C;
      #1;
      check("ld_stall_c2", stall_req, 1);
      step();
      mem_rvalid = 0;
      #1;
      check("ld_stall_done", stall_req, 0);
      check("ld_wb_data", wb_data, 8'h3C);
      check("ld_wb_rd", wb_rd, 5);
      check("ld_op2_fwd", op2, 8'h3C);

      // Load accept with mem_rvalid on the same edge: data ignored.
      op2_select = 0;
      ex_valid = 1; ex_rd = 6; ex_we = 1; ex_is_load = 1;
      mem_rvalid = 1; mem_rdata = 8'h55;
      step();
      ex_valid = 0; ex_is_load = 0;
      check("ld_early_rvalid_stall", stall_req, 1);
      check("ld_early_rvalid_data", wb_data, 0);
      // Flush and mem_rvalid together: flush wins.
      flush = 1; mem_rdata = 8'h99;
      step();
      flush = 0; mem_rvalid = 0;
      #1;
      check("flush_stall_req", stall_req, 0);
      check("flush_reg_we", reg_we, 0);
      check("flush_wb_data", wb_data, 0);
      check("flush_wb_rd", wb_rd, 0);

      // External stall holds the entry.
      ex_valid = 1; ex_rd = 2; ex_we = 1; ex_result = 8'h10;
      step();
      check("stl_wb_data_init", wb_data, 8'h10);
      stall = 1; ex_result = 8'h77;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("stl_hold_%0d", i), wb_data, 8'h10);
         check($sformatf("stl_req_%0d", i), stall_req, 0);
      end
      stall = 0;
      step();
      check("stl_release", wb_data, 8'h77);

      // Load completion is captured even under external stall.
      ex_rd = 4; ex_is_load = 1;
      step();
      ex_valid = 0; ex_is_load = 0;
      stall = 1; mem_rvalid = 1; mem_rdata = 8'hA5;
      step();
      mem_rvalid = 0;
      #1;
      check("ld_stall_cap_data", wb_data, 8'hA5);
      check("ld_stall_cap_req", stall_req, 0);
      check("ld_stall_cap_we", reg_we, 1);
      stall = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
